// File: rtl/v2f_arb_pkg.sv
// Shared types for the ALU arbiter: op codes, in-flight tag record, id width helper.
package v2f_arb_pkg;

   typedef enum logic [1:0] {
      OP_DIV = 2'd0,
      OP_MOD = 2'd1,
      OP_MUL = 2'd2,
      OP_POW = 2'd3
   } op_e;

   // Sized for the largest supported requester count (8).
   localparam int ID_W_MAX = 3;

   typedef struct packed {
      logic                valid;
      logic [ID_W_MAX-1:0] id;
      logic                dbz;
   } tag_t;

   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/v2f_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping.
// No state; the pointer register lives in the parent.
module v2f_rr_arbiter
   import v2f_arb_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IDW  = id_width(NREQ)
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [IDW-1:0]  ptr_i,
   output logic [NREQ-1:0] grant_o,
   output logic [IDW-1:0]  grant_idx_o
);

   int   idx;
   logic found;

   always_comb begin
      grant_o     = '0;
      grant_idx_o = '0;
      found       = 1'b0;
      idx         = 0;
      for (int i = 0; i < NREQ; i++) begin
         idx = (int'(ptr_i) + i) % NREQ;
         if (!found && req_i[idx]) begin
            found        = 1'b1;
            grant_o[idx] = 1'b1;
            grant_idx_o  = IDW'(idx);
         end
      end
   end

endmodule

// File: rtl/v2f_alu_arbiter.sv
// Shares one pipelined ALU among NREQ requesters; response LATENCY+2 cycles after handshake.
// Request side is valid/ready (one grant per cycle); responses have no backpressure.
module v2f_alu_arbiter
   import v2f_arb_pkg::*;
#(
   parameter int NREQ    = 4,
   parameter int WIDTH   = 32,
   parameter int LATENCY = 2,
   parameter int SIGNED  = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NREQ-1:0]    req_valid_i,
   output logic [NREQ-1:0]    req_ready_o,
   input  logic [2*NREQ-1:0]  req_op_i,
   input  logic [WIDTH*NREQ-1:0] req_a_i,
   input  logic [WIDTH*NREQ-1:0] req_b_i,
   output logic               alu_valid_o,
   output logic [1:0]         alu_op_o,
   output logic [WIDTH-1:0]   alu_a_o,
   output logic [WIDTH-1:0]   alu_b_o,
   output logic               alu_signed_o,
   input  logic [WIDTH-1:0]   alu_y_i,
   output logic [NREQ-1:0]    rsp_valid_o,
   output logic [WIDTH-1:0]   rsp_data_o,
   output logic               rsp_dbz_o,
   output logic               busy_o
);

   localparam int IDW = id_width(NREQ);

   logic [IDW-1:0]   ptr_q, ptr_d;
   logic [IDW-1:0]   grant_idx;
   logic [NREQ-1:0]  grant;
   logic             xfer;
   logic             trap;
   logic [1:0]       sel_op;
   logic [WIDTH-1:0] sel_a, sel_b;

   logic             alu_valid_q;
   logic [1:0]       alu_op_q;
   logic [WIDTH-1:0] alu_a_q, alu_b_q;
   logic [WIDTH-1:0] rsp_data_q;
   tag_t             iss_q, iss_d;
   tag_t             tag_q [LATENCY+1];

   v2f_rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
      .req_i       (req_valid_i),
      .ptr_i       (ptr_q),
      .grant_o     (grant),
      .grant_idx_o (grant_idx)
   );

   assign req_ready_o = grant;
   assign xfer        = |grant;
   assign sel_op      = req_op_i[2*grant_idx +: 2];
   assign sel_a       = req_a_i[WIDTH*grant_idx +: WIDTH];
   assign sel_b       = req_b_i[WIDTH*grant_idx +: WIDTH];
   assign trap        = xfer && (sel_op == OP_DIV || sel_op == OP_MOD) && (sel_b == '0);

   always_comb begin
      ptr_d = ptr_q;
      if (xfer) begin
         if (grant_idx == IDW'(NREQ-1)) ptr_d = '0;
         else                           ptr_d = grant_idx + 1'b1;
      end
      iss_d       = '0;
      iss_d.valid = xfer;
      iss_d.id    = ID_W_MAX'(grant_idx);
      iss_d.dbz   = trap;
   end

   // Operand registers only load on a transfer so the shared unit's inputs stay quiet when idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q       <= '0;
         alu_valid_q <= 1'b0;
         alu_op_q    <= '0;
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         iss_q       <= '0;
      end else begin
         ptr_q       <= ptr_d;
         alu_valid_q <= xfer & ~trap;
         iss_q       <= iss_d;
         if (xfer) begin
            alu_op_q <= sel_op;
            alu_a_q  <= sel_a;
            alu_b_q  <= sel_b;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i <= LATENCY; i++) tag_q[i] <= '0;
         rsp_data_q <= '0;
      end else begin
         tag_q[0] <= iss_q;
         for (int i = 1; i <= LATENCY; i++) tag_q[i] <= tag_q[i-1];
         // Capture the unit's result the cycle it is valid, one cycle before the tag emerges.
         if (tag_q[LATENCY-1].valid)
            rsp_data_q <= tag_q[LATENCY-1].dbz ? '0 : alu_y_i;
      end
   end

   always_comb begin
      for (int i = 0; i < NREQ; i++)
         rsp_valid_o[i] = tag_q[LATENCY].valid && (tag_q[LATENCY].id == ID_W_MAX'(i));
      busy_o = iss_q.valid;
      for (int i = 0; i <= LATENCY; i++) busy_o = busy_o | tag_q[i].valid;
   end

   assign rsp_dbz_o    = tag_q[LATENCY].valid & tag_q[LATENCY].dbz;
   assign rsp_data_o   = rsp_data_q;
   assign alu_valid_o  = alu_valid_q;
   assign alu_op_o     = alu_op_q;
   assign alu_a_o      = alu_a_q;
   assign alu_b_o      = alu_b_q;
   assign alu_signed_o = (SIGNED != 0);

endmodule

// File: tb/tb_v2f_alu_arbiter.sv
// Bench for v2f_alu_arbiter: directed vector table, multi-cycle sequences and a random scoreboard.
module tb_v2f_alu_arbiter;

   localparam int N   = 4;
   localparam int W   = 8;
   localparam int LAT = 2;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [N-1:0]   req_valid = '0;
   logic [N-1:0]   req_ready;
   logic [2*N-1:0] req_op = '0;
   logic [W*N-1:0] req_a = '0;
   logic [W*N-1:0] req_b = '0;
   logic           alu_valid;
   logic [1:0]     alu_op;
   logic [W-1:0]   alu_a, alu_b, alu_y;
   logic           alu_signed;
   logic [N-1:0]   rsp_valid;
   logic [W-1:0]   rsp_data;
   logic           rsp_dbz;
   logic           busy;

   int n_chk = 0;
   int n_pass = 0;
   int cyc = 0;

   v2f_alu_arbiter #(.NREQ(N), .WIDTH(W), .LATENCY(LAT), .SIGNED(1)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid_i(req_valid), .req_ready_o(req_ready),
      .req_op_i(req_op), .req_a_i(req_a), .req_b_i(req_b),
      .alu_valid_o(alu_valid), .alu_op_o(alu_op), .alu_a_o(alu_a), .alu_b_o(alu_b),
      .alu_signed_o(alu_signed), .alu_y_i(alu_y),
      .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data), .rsp_dbz_o(rsp_dbz), .busy_o(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
   endtask

   // Arithmetic the shared unit performs, signed operands, low W bits of the result.
   function automatic logic [W-1:0] alu_f(input logic [1:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
      int sa, sb, r;
      sa = int'($signed(a));
      sb = int'($signed(b));
      case (op)
         2'd0:    r = (sb == 0) ? 0 : sa / sb;
         2'd1:    r = (sb == 0) ? 0 : sa % sb;
         2'd2:    r = sa * sb;
         default: begin
            r = 1;
            for (int k = 0; k < int'(b); k++) r = r * sa;
         end
      endcase
      return r[W-1:0];
   endfunction

   // Shared unit stand-in: result LAT cycles after its inputs.
   logic [W-1:0] apipe [LAT];
   always @(posedge clk) begin
      apipe[0] <= alu_f(alu_op, alu_a, alu_b);
      for (int k = 1; k < LAT; k++) apipe[k] <= apipe[k-1];
   end
   assign alu_y = apipe[LAT-1];

   // ---------------- scoreboard ----------------
   typedef struct {
      int           due;
      int           id;
      logic [W-1:0] data;
      logic         dbz;
   } exp_t;

   exp_t         sq[$];
   int           mptr = 0;
   logic [N-1:0] hs_q = '0;
   bit           iss_pend = 0;
   bit           iss_dbz = 0;
   logic [1:0]   iss_op;
   logic [W-1:0] iss_a, iss_b;

   always @(negedge clk) begin
      if (!rst_n) begin
         sq.delete();
         mptr = 0;
         iss_pend = 0;
         hs_q = '0;
         chk("rst_busy", 32'(busy), 0);
         chk("rst_rsp_valid", 32'(rsp_valid), 0);
         chk("rst_alu_valid", 32'(alu_valid), 0);
      end else begin
         int g;
         bit exp_busy;
         logic [N-1:0] exp_rv;
         // issue stage from the previous cycle's handshake
         chk("sb_alu_valid", 32'(alu_valid), 32'(iss_pend && !iss_dbz));
         if (iss_pend && !iss_dbz) begin
            chk("sb_alu_a", 32'(alu_a), 32'(iss_a));
            chk("sb_alu_b", 32'(alu_b), 32'(iss_b));
            chk("sb_alu_op", 32'(alu_op), 32'(iss_op));
         end
         // busy: something handshaken earlier has not yet produced its response
         exp_busy = 0;
         foreach (sq[i]) if (sq[i].due >= cyc) exp_busy = 1;
         chk("sb_busy", 32'(busy), 32'(exp_busy));
         // response due now
         exp_rv = '0;
         if (sq.size() > 0 && sq[0].due == cyc) exp_rv[sq[0].id] = 1'b1;
         chk("sb_rsp_valid", 32'(rsp_valid), 32'(exp_rv));
         if (exp_rv != '0) begin
            chk("sb_rsp_data", 32'(rsp_data), 32'(sq[0].data));
            chk("sb_rsp_dbz", 32'(rsp_dbz), 32'(sq[0].dbz));
            void'(sq.pop_front());
         end else begin
            chk("sb_rsp_dbz_idle", 32'(rsp_dbz), 0);
         end
         // arbitration rule: first valid at or after the pointer
         g = -1;
         for (int i = 0; i < N; i++)
            if (g < 0 && req_valid[(mptr + i) % N]) g = (mptr + i) % N;
         chk("sb_req_ready", 32'(req_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
         iss_pend = 0;
         hs_q = '0;
         if (g >= 0) begin
            exp_t e;
            iss_op  = req_op[2*g +: 2];
            iss_a   = req_a[W*g +: W];
            iss_b   = req_b[W*g +: W];
            iss_dbz = (iss_op <= 2'd1) && (iss_b == '0);
            iss_pend = 1;
            e.due  = cyc + LAT + 2;
            e.id   = g;
            e.dbz  = iss_dbz;
            e.data = iss_dbz ? '0 : alu_f(iss_op, iss_a, iss_b);
            sq.push_back(e);
            mptr = (g + 1) % N;
            hs_q[g] = 1'b1;
         end
      end
   end

   // ---------------- directed vectors ----------------
   typedef struct {
      int           rq;
      logic [1:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] y;
      logic         dbz;
   } vec_t;

   vec_t tbl[8];

   task automatic set_req(input int r, input logic [1:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b);
      req_op[2*r +: 2] = op;
      req_a[W*r +: W]  = a;
      req_b[W*r +: W]  = b;
   endtask

   task automatic run_vec(input vec_t v);
      @(posedge clk); #1;
      set_req(v.rq, v.op, v.a, v.b);
      req_valid = '0;
      req_valid[v.rq] = 1'b1;
      @(negedge clk);
      chk("vec_ready", 32'(req_ready), 32'd1 << v.rq);
      @(posedge clk); #1;
      req_valid = '0;
      @(negedge clk);
      chk("vec_alu_valid", 32'(alu_valid), 32'(!v.dbz));
      if (!v.dbz) begin
         chk("vec_alu_a", 32'(alu_a), 32'(v.a));
         chk("vec_alu_b", 32'(alu_b), 32'(v.b));
      end
      repeat (LAT + 1) @(negedge clk);
      chk("vec_rsp_valid", 32'(rsp_valid), 32'd1 << v.rq);
      chk("vec_rsp_data", 32'(rsp_data), 32'(v.y));
      chk("vec_rsp_dbz", 32'(rsp_dbz), 32'(v.dbz));
      @(negedge clk);
      chk("vec_rsp_gone", 32'(rsp_valid), 0);
   endtask

   task automatic pulse_reset();
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   initial begin
      tbl[0] = '{0, 2'd0, 8'd100, 8'd7,  8'd14,  1'b0};
      tbl[1] = '{2, 2'd1, 8'd5,   8'd0,  8'd0,   1'b1};
      tbl[2] = '{3, 2'd2, 8'hFD,  8'd4,  8'hF4,  1'b0};
      tbl[3] = '{1, 2'd3, 8'd2,   8'd10, 8'h00,  1'b0};
      tbl[4] = '{1, 2'd2, 8'd15,  8'd17, 8'hFF,  1'b0};
      tbl[5] = '{0, 2'd0, 8'h9C,  8'd7,  8'hF2,  1'b0};
      tbl[6] = '{1, 2'd1, 8'hF9,  8'd3,  8'hFF,  1'b0};
      tbl[7] = '{3, 2'd0, 8'd9,   8'd0,  8'd0,   1'b1};

      repeat (3) @(posedge clk);
      chk("rst_alu_signed", 32'(alu_signed), 1);
      chk("rst_rsp_data", 32'(rsp_data), 0);
      #1 rst_n = 1'b1;

      foreach (tbl[i]) run_vec(tbl[i]);

      // trapped mod followed immediately by a mul from another requester
      begin
         int t;
         @(posedge clk); #1;
         set_req(2, 2'd1, 8'd5, 8'd0);
         set_req(3, 2'd2, 8'hFD, 8'd4);
         req_valid = 4'b0100;
         @(posedge clk); #1;
         req_valid = 4'b1000;
         t = cyc;
         @(negedge clk);
         chk("dbz_alu_quiet", 32'(alu_valid), 0);
         @(posedge clk); #1;
         req_valid = '0;
         repeat (3) @(negedge clk);
         chk("dbz_rsp_valid", 32'(rsp_valid), 32'b0100);
         chk("dbz_rsp_data", 32'(rsp_data), 0);
         chk("dbz_rsp_flag", 32'(rsp_dbz), 1);
         @(negedge clk);
         chk("dbz_mul_valid", 32'(rsp_valid), 32'b1000);
         chk("dbz_mul_data", 32'(rsp_data), 32'hF4);
         chk("dbz_mul_flag", 32'(rsp_dbz), 0);
      end

      // round robin with everyone requesting from pointer 0
      pulse_reset();
      for (int r = 0; r < N; r++) set_req(r, 2'd2, 8'(r + 1), 8'd3);
      req_valid = '1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (k < 6) chk("rr_grant", 32'(req_ready), 32'd1 << (k % N));
         if (k >= 4) chk("rr_rsp", 32'(rsp_valid), 32'd1 << ((k - 4) % N));
         if (k == 5) begin
            @(posedge clk); #1;
            req_valid = '0;
         end
      end

      // sparse requests with pointer wrap (pointer is 2 here, request 2 moves it to 3)
      @(posedge clk); #1;
      req_valid = 4'b0100;
      @(posedge clk); #1;
      req_valid = 4'b1010;
      @(negedge clk);
      chk("wrap_grant3", 32'(req_ready), 32'b1000);
      @(posedge clk); #1;
      req_valid = 4'b0010;
      @(negedge clk);
      chk("wrap_grant1", 32'(req_ready), 32'b0010);
      @(posedge clk); #1;
      req_valid = 4'b1101;
      @(negedge clk);
      chk("wrap_grant2", 32'(req_ready), 32'b0100);
      @(posedge clk); #1;
      req_valid = '0;
      repeat (6) @(posedge clk);

      // reset while three ops are in flight
      #1;
      req_valid = 4'b0001;
      @(posedge clk); #1;
      req_valid = 4'b0010;
      @(posedge clk); #1;
      req_valid = 4'b0100;
      @(posedge clk); #1;
      req_valid = '0;
      rst_n = 1'b0;
      #1;
      chk("midrst_busy", 32'(busy), 0);
      chk("midrst_rsp", 32'(rsp_valid), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (6) begin
         @(negedge clk);
         chk("midrst_no_rsp", 32'(rsp_valid), 0);
      end
      @(posedge clk); #1;
      req_valid = 4'b1001;
      @(negedge clk);
      chk("midrst_ptr0", 32'(req_ready), 32'b0001);
      @(posedge clk); #1;
      req_valid = '0;
      repeat (6) @(posedge clk);

      // random traffic; a requester only changes its request after a handshake
      for (int c = 0; c < 400; c++) begin
         @(posedge clk); #1;
         for (int r = 0; r < N; r++) begin
            if (!req_valid[r] || hs_q[r]) begin
               if ($urandom_range(0, 3) != 0) begin
                  set_req(r, 2'($urandom_range(0, 3)), 8'($urandom),
                          ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(0, 255)));
                  req_valid[r] = 1'b1;
               end else begin
                  req_valid[r] = 1'b0;
               end
            end
         end
      end
      @(posedge clk); #1;
      req_valid = '0;
      repeat (LAT + 4) @(posedge clk);
      @(negedge clk);
      chk("drain_busy", 32'(busy), 0);
      chk("drain_queue_empty", 32'(sq.size()), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/v2f_alu_arbiter.md
Name: v2f_alu_arbiter

Overview:
- Shares one multi-cycle arithmetic unit among NREQ requesters. The unit is a v2f_div / v2f_mod / v2f_mul / v2f_pow instance set behind a common op select.
- Round-robin arbitration; valid/ready request handshake; fully pipelined issue of one op per cycle.
- Tags in-flight ops so each result returns to its originating requester.
- Divide-by-zero is trapped locally; such requests never reach the shared unit.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 32, operand and result width.
- LATENCY, 2, fixed cycles from alu_valid to alu_y valid (≥1).
- SIGNED, 1, operands treated as signed; passed through on alu_signed.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester grant; a transfer occurs when valid&ready are both high.
- req_op  in  2*NREQ  op per requester: 0 div, 1 mod, 2 mul, 3 pow.
- req_a  in  WIDTH*NREQ  operand A per requester.
- req_b  in  WIDTH*NREQ  operand B per requester.
- alu_valid  out  1  issue strobe to the shared unit.
- alu_op  out  2  op select to the shared unit.
- alu_a  out  WIDTH  operand A to the shared unit.
- alu_b  out  WIDTH  operand B to the shared unit.
- alu_signed  out  1  constant SIGNED.
- alu_y  in  WIDTH  shared-unit result, valid LATENCY cycles after alu_valid.
- rsp_valid  out  NREQ  one-hot, pulses for one cycle.
- rsp_data  out  WIDTH  result shared across requesters; qualified by rsp_valid.
- rsp_dbz  out  1  result came from the divide-by-zero trap.
- busy  out  1  any op in flight.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values:
  - all outputs 0, except alu_signed = SIGNED;
  - round-robin pointer = 0;
  - tag pipeline cleared.
- Arbitration (combinational):
  - Grant the first asserted req_valid at or after the pointer, wrapping modulo NREQ.
  - req_ready is one-hot on the granted index, 0 if none valid.
  - req_ready never asserts without the matching req_valid.
  - Requests held while waiting must keep op/a/b stable; the design does not check this.
- Pointer: on a transfer from index g, pointer <= (g+1) mod NREQ. With no transfer, the pointer holds.
- Issue stage (registered): on a transfer at cycle t, alu_a/alu_b/alu_op are loaded.
  - alu_valid = 1 in cycle t+1, unless the trap fires.
  - Trap: op ∈ {0,1} and b == 0. Then alu_valid stays 0 and the tag is marked dbz.
  - With no transfer, alu_valid = 0 and alu_a/alu_b/alu_op hold their last values, so the unit inputs do not toggle.
- Tag pipeline: LATENCY+1 stages of {valid, id[$clog2(NREQ)], dbz}, shifting every cycle with no stall.
- Response: in cycle t+2+LATENCY:
  - rsp_valid[id] = 1;
  - rsp_data = dbz ? 0 : alu_y as sampled in cycle t+1+LATENCY;
  - rsp_dbz = dbz.
- Latency and throughput:
  - fixed latency LATENCY+2 cycles from handshake to response, identical for trapped ops;
  - responses stay in issue order;
  - peak throughput one op per cycle.
- No response backpressure: requesters must accept rsp_valid when it arrives.
- Outputs when idle: rsp_valid = 0, rsp_dbz = 0; rsp_data holds its last value.
- busy: OR of the issue-stage valid and all tag-stage valids.
- Boundary cases:
  - NREQ = 1: always grant index 0; pointer stays 0.
  - Pointer wrap: from NREQ-1 the pointer goes to 0.
  - Simultaneous requests from all requesters: each is served exactly once per NREQ cycles.
  - A requester whose response arrives while it issues a new request: both events occur in the same cycle, independently.
  - rst_n asserted mid-operation: in-flight tags are discarded, no rsp_valid is emitted, and the pointer returns to 0.
  - mul/pow results are the low WIDTH bits of alu_y; the shared unit's Y_WIDTH = WIDTH.

Decomposition:
- Package v2f_arb_pkg:
  - op codes OP_DIV=0, OP_MOD=1, OP_MUL=2, OP_POW=3;
  - tag struct {valid, id, dbz};
  - function for the id width.
- Sub-module v2f_rr_arbiter (NREQ):
  - inputs req, ptr;
  - outputs grant one-hot and grant_idx;
  - purely combinational. The pointer register lives in the parent.

Test Plan:
- Single request (LATENCY=2): req 0 div, a=100, b=7, handshake at cycle 5.
  - alu_valid in cycle 6 with a=100, b=7, op=0.
  - rsp_valid[0] in cycle 9, rsp_data=14, rsp_dbz=0.
- Round-robin: all four requesters valid continuously from cycle 0, pointer=0.
  - Grants 0,1,2,3,0,1 in cycles 0–5.
  - Responses in the same order, one per cycle, starting in cycle 4.
- Divide-by-zero: req 2 mod, a=5, b=0.
  - alu_valid stays 0.
  - rsp_valid[2] four cycles later, rsp_data=0, rsp_dbz=1.
  - A mul issued the next cycle by req 3 (a=-3, b=4, SIGNED=1) returns -12 one cycle after the trapped response.
- Sparse and wrap: req 3 then req 1 valid with the pointer at 3.
  - Grant 3, pointer goes to 0.
  - Next grant is 1, pointer goes to 2.
- Reset mid-flight: three ops issued, rst_n pulsed low for 1 cycle.
  - No rsp_valid afterwards.
  - busy=0 and pointer=0 immediately on assertion.
  - The next request is served from index 0.
- Pow and width check: req 1 pow, a=2, b=10, WIDTH=8.
  - rsp_data=0x00, the low 8 bits of 1024.
  - A back-to-back mul 15*17 from req 1 returns 0xFF.
